// File: rtl/id_hazard_ctrl_pkg.sv
// Shared definitions for the decode-stage hazard controller.
//   - hz_state_e : issue FSM states (RUN / DRAIN / FLUSH)
//   - REG_ADDR_W : architectural register index width
//   - OPC_*      : major opcode classes used upstream to derive the
//                  rs*_used / rd_we / serialize decode flags
package id_hazard_ctrl_pkg;

   localparam int unsigned REG_ADDR_W = 5;

   typedef enum logic [1:0] {
      HZ_RUN   = 2'd0,
      HZ_DRAIN = 2'd1,
      HZ_FLUSH = 2'd2
   } hz_state_e;

   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   // FENCE and CSR/SYSTEM instructions must issue into an empty machine.
   function automatic logic is_serializing(input logic [6:0] opc);
      return (opc == OPC_MISC_MEM) || (opc == OPC_SYSTEM);
   endfunction

endpackage

// File: rtl/id_hazard_ctrl_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register plus a
// registered count of set bits.
//   clk, rst           : clock, synchronous active-high reset
//   set_en, set_idx    : mark a register pending (index 0 ignored)
//   clr_en, clr_idx    : write-back; clears only if the entry is pending
//   rd_a_idx, rd_b_idx : read port indices -> rd_a, rd_b
//   pend               : full pending vector
//   count              : number of pending entries (registered)
//   drained_nxt        : count will be zero after this edge
module hz_scoreboard
   import id_hazard_ctrl_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  set_en,
   input  logic [REG_ADDR_W-1:0] set_idx,
   input  logic                  clr_en,
   input  logic [REG_ADDR_W-1:0] clr_idx,
   input  logic [REG_ADDR_W-1:0] rd_a_idx,
   input  logic [REG_ADDR_W-1:0] rd_b_idx,
   output logic                  rd_a,
   output logic                  rd_b,
   output logic [31:0]           pend,
   output logic [4:0]            count,
   output logic                  drained_nxt
);

   logic [31:0] sb, sb_nxt;
   logic [4:0]  cnt, cnt_nxt;
   logic        set_hit, clr_hit;

   always_comb begin
      set_hit = set_en & (set_idx != '0);
      clr_hit = clr_en & (clr_idx != '0) & sb[clr_idx];
      sb_nxt  = sb;
      if (clr_hit) sb_nxt[clr_idx] = 1'b0;
      // Applied after the clear so a same-index set/clear leaves the bit set.
      if (set_hit) sb_nxt[set_idx] = 1'b1;
      cnt_nxt = cnt;
      if (set_hit && !clr_hit)      cnt_nxt = cnt + 5'd1;
      else if (clr_hit && !set_hit) cnt_nxt = cnt - 5'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sb  <= '0;
         cnt <= '0;
      end else begin
         sb  <= sb_nxt;
         cnt <= cnt_nxt;
      end
   end

   assign rd_a        = sb[rd_a_idx];
   assign rd_b        = sb[rd_b_idx];
   assign pend        = sb;
   assign count       = cnt;
   assign drained_nxt = (cnt_nxt == '0);

endmodule

// File: rtl/id_hazard_ctrl.sv
// Decode-stage issue controller. Stalls the decode slot on RAW/WAW hazards
// against in-flight writes, when MAX_OUTSTANDING writes are in flight, and
// holds serializing instructions until the scoreboard drains.
//   clk, rst                 : clock, synchronous active-high reset
//   i_id_valid ... i_flush   : decode-slot instruction fields and controls
//   i_wb_wr, i_wb_rd         : WB register-file write port
//   o_issue                  : instruction moves to EX this cycle (comb)
//   o_id_ready               : IF/ID may advance (comb)
//   o_outstanding            : in-flight write count (registered)
//   o_stall_cycles           : saturating stall counter (registered)
module id_hazard_ctrl
   import id_hazard_ctrl_pkg::*;
#(
   parameter int unsigned MAX_OUTSTANDING = 4,
   parameter bit          WB_BYPASS       = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_id_valid,
   input  logic [REG_ADDR_W-1:0] i_rs1,
   input  logic [REG_ADDR_W-1:0] i_rs2,
   input  logic                  i_rs1_used,
   input  logic                  i_rs2_used,
   input  logic [REG_ADDR_W-1:0] i_rd,
   input  logic                  i_rd_we,
   input  logic                  i_serialize,
   input  logic                  i_ex_ready,
   input  logic                  i_flush,
   input  logic                  i_wb_wr,
   input  logic [REG_ADDR_W-1:0] i_wb_rd,
   output logic                  o_issue,
   output logic                  o_id_ready,
   output logic [4:0]            o_outstanding,
   output logic [31:0]           o_stall_cycles
);

   localparam logic [4:0] MAX_CNT = 5'(MAX_OUTSTANDING);

   hz_state_e   state, state_nxt;
   logic [31:0] sb_vec;
   logic [4:0]  count;
   logic        sb_rs1, sb_rs2, drained_nxt;
   logic        pend_rs1, pend_rs2, pend_rd;
   logic        hazard, full, ser_block, run;
   logic [31:0] stall_cnt;

   hz_scoreboard u_sb (
      .clk         (clk),
      .rst         (rst),
      .set_en      (o_issue & i_rd_we),
      .set_idx     (i_rd),
      .clr_en      (i_wb_wr),
      .clr_idx     (i_wb_rd),
      .rd_a_idx    (i_rs1),
      .rd_b_idx    (i_rs2),
      .rd_a        (sb_rs1),
      .rd_b        (sb_rs2),
      .pend        (sb_vec),
      .count       (count),
      .drained_nxt (drained_nxt)
   );

   // With a write-through register file a WB landing this cycle already
   // satisfies the reader, so the pending bit is masked.
   always_comb begin
      pend_rs1  = sb_rs1     & (i_rs1 != '0) & ~(WB_BYPASS & i_wb_wr & (i_wb_rd == i_rs1));
      pend_rs2  = sb_rs2     & (i_rs2 != '0) & ~(WB_BYPASS & i_wb_wr & (i_wb_rd == i_rs2));
      pend_rd   = sb_vec[i_rd] & (i_rd != '0) & ~(WB_BYPASS & i_wb_wr & (i_wb_rd == i_rd));
      hazard    = (i_rs1_used & pend_rs1) | (i_rs2_used & pend_rs2) | (i_rd_we & pend_rd);
      full      = (count == MAX_CNT) & i_rd_we & (i_rd != '0);
      ser_block = i_serialize & (count != '0);
      run       = (state == HZ_RUN) & ~rst;
      o_issue   = run & i_id_valid & i_ex_ready & ~i_flush & ~hazard & ~full & ~ser_block;
      o_id_ready = run & (o_issue | ~i_id_valid);
   end

   always_comb begin
      state_nxt = state;
      if (i_flush) begin
         state_nxt = HZ_FLUSH;
      end else begin
         case (state)
            HZ_RUN:   if (i_id_valid & i_serialize & (count != '0)) state_nxt = HZ_DRAIN;
            HZ_DRAIN: if (drained_nxt) state_nxt = HZ_RUN;
            HZ_FLUSH: state_nxt = HZ_RUN;
            default:  state_nxt = HZ_RUN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= HZ_RUN;
         stall_cnt <= '0;
      end else begin
         state <= state_nxt;
         if ((state != HZ_FLUSH) && i_id_valid && !o_issue && !i_flush && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 32'd1;
      end
   end

   assign o_outstanding  = count;
   assign o_stall_cycles = stall_cnt;

endmodule

// File: tb/tb_id_hazard_ctrl.sv
module tb_id_hazard_ctrl;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int unsigned total = 0;
   int unsigned bad   = 0;

   // DUT A: WB_BYPASS=0, DUT B: WB_BYPASS=1 (both MAX_OUTSTANDING=4)
   logic       a_valid, a_u1, a_u2, a_we, a_ser, a_rdy, a_flush, a_wbwr;
   logic [4:0] a_rs1, a_rs2, a_rd, a_wbrd;
   logic       a_issue, a_idr;
   logic [4:0] a_out;
   logic [31:0] a_stall;

   logic       b_valid, b_u1, b_u2, b_we, b_ser, b_rdy, b_flush, b_wbwr;
   logic [4:0] b_rs1, b_rs2, b_rd, b_wbrd;
   logic       b_issue, b_idr;
   logic [4:0] b_out;
   logic [31:0] b_stall;

   id_hazard_ctrl #(.MAX_OUTSTANDING(4), .WB_BYPASS(1'b0)) dut_a (
      .clk(clk), .rst(rst), .i_id_valid(a_valid), .i_rs1(a_rs1), .i_rs2(a_rs2),
      .i_rs1_used(a_u1), .i_rs2_used(a_u2), .i_rd(a_rd), .i_rd_we(a_we),
      .i_serialize(a_ser), .i_ex_ready(a_rdy), .i_flush(a_flush),
      .i_wb_wr(a_wbwr), .i_wb_rd(a_wbrd), .o_issue(a_issue), .o_id_ready(a_idr),
      .o_outstanding(a_out), .o_stall_cycles(a_stall));

   id_hazard_ctrl #(.MAX_OUTSTANDING(4), .WB_BYPASS(1'b1)) dut_b (
      .clk(clk), .rst(rst), .i_id_valid(b_valid), .i_rs1(b_rs1), .i_rs2(b_rs2),
      .i_rs1_used(b_u1), .i_rs2_used(b_u2), .i_rd(b_rd), .i_rd_we(b_we),
      .i_serialize(b_ser), .i_ex_ready(b_rdy), .i_flush(b_flush),
      .i_wb_wr(b_wbwr), .i_wb_rd(b_wbrd), .o_issue(b_issue), .o_id_ready(b_idr),
      .o_outstanding(b_out), .o_stall_cycles(b_stall));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_a(input logic v, input logic [4:0] r1, input logic u1,
                          input logic [4:0] r2, input logic u2,
                          input logic [4:0] rd, input logic we, input logic ser);
      a_valid = v; a_rs1 = r1; a_u1 = u1; a_rs2 = r2; a_u2 = u2;
      a_rd = rd; a_we = we; a_ser = ser; a_rdy = 1'b1;
   endtask

   task automatic drive_b(input logic v, input logic [4:0] r1, input logic u1,
                          input logic [4:0] rd, input logic we);
      b_valid = v; b_rs1 = r1; b_u1 = u1; b_rs2 = 5'd0; b_u2 = 1'b0;
      b_rd = rd; b_we = we; b_ser = 1'b0; b_rdy = 1'b1; b_flush = 1'b0;
   endtask

   task automatic wb_a(input logic wr, input logic [4:0] rd);
      a_wbwr = wr; a_wbrd = rd;
   endtask

   task automatic wb_b(input logic wr, input logic [4:0] rd);
      b_wbwr = wr; b_wbrd = rd;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive_a(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0); a_flush = 1'b0; wb_a(1'b0, 5'd0);
      drive_b(1'b1, 5'd0, 1'b0, 5'd1, 1'b1); wb_b(1'b0, 5'd0);
      tick(); #1;
      total++; if (a_issue !== 1'b0) begin bad++; $display("FAIL rst_issue_c1: got=%b want=0", a_issue); end
      total++; if (a_idr !== 1'b0) begin bad++; $display("FAIL rst_idready_c1: got=%b want=0", a_idr); end
      tick(); #1;
      total++; if (a_issue !== 1'b0) begin bad++; $display("FAIL rst_issue_c2: got=%b want=0", a_issue); end
      total++; if (b_idr !== 1'b0) begin bad++; $display("FAIL rst_idready_b: got=%b want=0", b_idr); end
      rst = 1'b0;
      drive_a(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      drive_b(1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
      #1;
      total++; if (a_out !== 5'd0) begin bad++; $display("FAIL rst_outstanding: got=%0d want=0", a_out); end
      total++; if (a_stall !== 32'd0) begin bad++; $display("FAIL rst_stall: got=%0d want=0", a_stall); end
      total++; if (b_out !== 5'd0) begin bad++; $display("FAIL rst_outstanding_b: got=%0d want=0", b_out); end
   endtask

   task automatic test_raw();
      drive_a(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0); #1;
      total++; if (a_issue !== 1'b1) begin bad++; $display("FAIL raw_producer_issue: got=%b want=1", a_issue); end
      tick();
      total++; if (a_out !== 5'd1) begin bad++; $display("FAIL raw_outstanding: got=%0d want=1", a_out); end
      drive_a(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0); #1;
      total++; if (a_issue !== 1'b0) begin bad++; $display("FAIL raw_consumer_stall: got=%b want=0", a_issue); end
      total++; if (a_idr !== 1'b0) begin bad++; $display("FAIL raw_idready: got=%b want=0", a_idr); end
      tick(); tick();
      total++; if (a_stall !== 32'd2) begin bad++; $display("FAIL raw_stall_count: got=%0d want=2", a_stall); end
      wb_a(1'b1, 5'd5); #1;
      total++; if (a_issue !== 1'b0) begin bad++; $display("FAIL raw_nobypass_wb_cycle: got=%b want=0", a_issue); end
      tick();
      wb_a(1'b0, 5'd0); #1;
      total++; if (a_issue !== 1'b1) begin bad++; $display("FAIL raw_issue_after_wb: got=%b want=1", a_issue); end
      tick();
      drive_a(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); #1;
      total++; if (a_out !== 5'd1) begin bad++; $display("FAIL raw_out_after: got=%0d want=1", a_out); end
      total++; if (a_stall !== 32'd3) begin bad++; $display("FAIL raw_stall_final: got=%0d want=3", a_stall); end
      wb_a(1'b1, 5'd6); tick(); wb_a(1'b0, 5'd0); #1;
      total++; if (a_out !== 5'd0) begin bad++; $display("FAIL raw_drain: got=%0d want=0", a_out); end
   endtask

   task automatic test_full();
      for (int i = 1; i <= 4; i++) begin
         drive_a(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'(i), 1'b1, 1'b0);
         tick();
      end
      #1;
      total++; if (a_out !== 5'd4) begin bad++; $display("FAIL full_outstanding: got=%0d want=4", a_out); end
      drive_a(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0); #1;
      total++; if (a_issue !== 1'b0) begin bad++; $display("FAIL full_fifth_write: got=%b want=0", a_issue); end
      drive_a(1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 1'b0); #1;
      total++; if (a_issue !== 1'b1) begin bad++; $display("FAIL full_store_issue: got=%b want=1", a_issue); end
      total++; if (a_idr !== 1'b1) begin bad++; $display("FAIL full_store_idready: got=%b want=1", a_idr); end
      drive_a(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0); wb_a(1'b1, 5'd2); #1;
      total++; if (a_issue !== 1'b0) begin bad++; $display("FAIL full_wb_cycle: got=%b want=0", a_issue); end
      tick();
      wb_a(1'b0, 5'd0); #1;
      total++; if (a_issue !== 1'b1) begin bad++; $display("FAIL full_issue_after_wb: got=%b want=1", a_issue); end
      tick();
      drive_a(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); #1;
      total++; if (a_out !== 5'd4) begin bad++; $display("FAIL full_refill: got=%0d want=4", a_out); end
      wb_a(1'b1, 5'd1); tick();
      wb_a(1'b1, 5'd3); tick();
      wb_a(1'b1, 5'd4); tick();
      wb_a(1'b1, 5'd6); tick();
      wb_a(1'b0, 5'd0); #1;
      total++; if (a_out !== 5'd0) begin bad++; $display("FAIL full_drain: got=%0d want=0", a_out); end
      total++; if (a_stall !== 32'd4) begin bad++; $display("FAIL full_stall: got=%0d want=4", a_stall); end
   endtask

   task automatic test_serialize();
      drive_a(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0); tick();
      drive_a(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1); #1;
      total++; if (a_issue !== 1'b0) begin bad++; $display("FAIL ser_blocked: got=%b want=0", a_issue); end
      tick();
      wb_a(1'b1, 5'd3); #1;
      total++; if (a_idr !== 1'b0) begin bad++; $display("FAIL ser_drain_idready: got=%b want=0", a_idr); end
      total++; if (a_issue !== 1'b0) begin bad++; $display("FAIL ser_drain_issue: got=%b want=0", a_issue); end
      tick();
      wb_a(1'b0, 5'd0); #1;
      total++; if (a_out !== 5'd0) begin bad++; $display("FAIL ser_outstanding: got=%0d want=0", a_out); end
      total++; if (a_issue !== 1'b1) begin bad++; $display("FAIL ser_issue_run: got=%b want=1", a_issue); end
      total++; if (a_idr !== 1'b1) begin bad++; $display("FAIL ser_idready_run: got=%b want=1", a_idr); end
      tick();
      drive_a(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); #1;
      total++; if (a_stall !== 32'd6) begin bad++; $display("FAIL ser_stall: got=%0d want=6", a_stall); end
   endtask

   task automatic test_flush();
      drive_a(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0); tick();
      drive_a(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1); tick();
      a_flush = 1'b1; #1;
      total++; if (a_issue !== 1'b0) begin bad++; $display("FAIL flush_drain_issue: got=%b want=0", a_issue); end
      tick();
      a_flush = 1'b0;
      drive_a(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); #1;
      total++; if (a_issue !== 1'b0) begin bad++; $display("FAIL flush_state_issue: got=%b want=0", a_issue); end
      total++; if (a_idr !== 1'b0) begin bad++; $display("FAIL flush_state_idready: got=%b want=0", a_idr); end
      tick();
      total++; if (a_issue !== 1'b1) begin bad++; $display("FAIL flush_back_to_run: got=%b want=1", a_issue); end
      total++; if (a_out !== 5'd1) begin bad++; $display("FAIL flush_sb_kept: got=%0d want=1", a_out); end
      drive_a(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      wb_a(1'b1, 5'd3); tick(); wb_a(1'b0, 5'd0); #1;
      total++; if (a_out !== 5'd0) begin bad++; $display("FAIL flush_wb_clear: got=%0d want=0", a_out); end
      total++; if (a_stall !== 32'd7) begin bad++; $display("FAIL flush_stall: got=%0d want=7", a_stall); end
   endtask

   task automatic test_x0_spurious();
      drive_a(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0); #1;
      total++; if (a_issue !== 1'b1) begin bad++; $display("FAIL x0_issue: got=%b want=1", a_issue); end
      tick();
      drive_a(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); #1;
      total++; if (a_out !== 5'd0) begin bad++; $display("FAIL x0_not_pending: got=%0d want=0", a_out); end
      wb_a(1'b1, 5'd7); tick(); wb_a(1'b0, 5'd0); #1;
      total++; if (a_out !== 5'd0) begin bad++; $display("FAIL spurious_wb: got=%0d want=0", a_out); end
   endtask

   task automatic test_bypass();
      drive_b(1'b1, 5'd0, 1'b0, 5'd5, 1'b1); tick();
      drive_b(1'b1, 5'd5, 1'b1, 5'd6, 1'b1); #1;
      total++; if (b_issue !== 1'b0) begin bad++; $display("FAIL byp_stall: got=%b want=0", b_issue); end
      tick();
      wb_b(1'b1, 5'd5); #1;
      total++; if (b_issue !== 1'b1) begin bad++; $display("FAIL byp_same_cycle_issue: got=%b want=1", b_issue); end
      tick();
      wb_b(1'b0, 5'd0); drive_b(1'b0, 5'd0, 1'b0, 5'd0, 1'b0); #1;
      total++; if (b_out !== 5'd1) begin bad++; $display("FAIL byp_outstanding: got=%0d want=1", b_out); end
      total++; if (b_stall !== 32'd1) begin bad++; $display("FAIL byp_stall_cnt: got=%0d want=1", b_stall); end
      drive_b(1'b1, 5'd0, 1'b0, 5'd9, 1'b1); tick();
      wb_b(1'b1, 5'd9); #1;
      total++; if (b_issue !== 1'b1) begin bad++; $display("FAIL byp_waw_issue: got=%b want=1", b_issue); end
      tick();
      wb_b(1'b0, 5'd0); drive_b(1'b0, 5'd0, 1'b0, 5'd0, 1'b0); #1;
      total++; if (b_out !== 5'd2) begin bad++; $display("FAIL byp_set_wins_count: got=%0d want=2", b_out); end
      wb_b(1'b1, 5'd9); tick(); wb_b(1'b0, 5'd0); #1;
      total++; if (b_out !== 5'd1) begin bad++; $display("FAIL byp_x9_still_set: got=%0d want=1", b_out); end
      wb_b(1'b1, 5'd6); tick(); wb_b(1'b0, 5'd0); #1;
      total++; if (b_out !== 5'd0) begin bad++; $display("FAIL byp_drain: got=%0d want=0", b_out); end
   endtask

   initial begin
      test_reset();
      test_raw();
      test_full();
      test_serialize();
      test_flush();
      test_x0_spurious();
      test_bypass();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/id_hazard_ctrl.md
Name: id_hazard_ctrl

Overview:
Scoreboard-based issue controller for the decode stage.
- Tracks which architectural registers have an issued-but-not-written-back producer.
- Stalls the decode slot on RAW/WAW hazards, when the outstanding-write limit is reached, and for serializing instructions (FENCE/CSR) until the machine drains.
- Sits between the IF/ID register and the ID/EX register; its inputs come from the decode field extraction (rs1/rs2/rd/opcode class) and from the WB stage's register-file write port.

Parameters:
MAX_OUTSTANDING, 4, maximum number of in-flight register writes (1..31).
WB_BYPASS, 0, 1 = a same-cycle WB write to a pending register clears the hazard (register file is write-through); 0 = it still counts as a hazard.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
i_id_valid  in  1  decode slot holds a valid instruction
i_rs1  in  5  source register 1 index
i_rs2  in  5  source register 2 index
i_rs1_used  in  1  instruction reads rs1
i_rs2_used  in  1  instruction reads rs2
i_rd  in  5  destination register index
i_rd_we  in  1  instruction writes rd
i_serialize  in  1  instruction must issue with an empty scoreboard
i_ex_ready  in  1  ID/EX register can accept
i_flush  in  1  kill the decode-slot instruction (branch/jump redirect)
i_wb_wr  in  1  WB register-file write enable
i_wb_rd  in  5  WB destination index
o_issue  out  1  instruction moves to EX this cycle (combinational)
o_id_ready  out  1  IF/ID may advance (combinational)
o_outstanding  out  5  current in-flight write count (registered)
o_stall_cycles  out  32  saturating stall performance counter (registered)

Behaviour:
- Reset (rst high at clk edge):
  - scoreboard sb[31:0]=0, count=0, state=RUN, stall counter=0.
  - While rst is high, o_issue=0 and o_id_ready=0.
- Register x0 is never marked pending; index 0 is ignored on set, clear and hazard check.
- hazard = (i_rs1_used & pend(i_rs1)) | (i_rs2_used & pend(i_rs2)) | (i_rd_we & pend(i_rd)).
  - pend(r) = sb[r] & ~(WB_BYPASS & i_wb_wr & i_wb_rd==r).
- full = (count == MAX_OUTSTANDING) & i_rd_we & i_rd!=0.
  - A non-writing instruction may issue while full.
- Serialize block: i_serialize & count!=0.
- o_issue = state==RUN & i_id_valid & i_ex_ready & ~i_flush & ~hazard & ~full & ~(serialize block).
- o_id_ready:
  - = o_issue | ~i_id_valid in RUN;
  - = 0 in DRAIN and FLUSH.
- Scoreboard update per clock edge:
  - set sb[i_rd] when o_issue & i_rd_we & i_rd!=0;
  - clear sb[i_wb_rd] when i_wb_wr & sb[i_wb_rd] & i_wb_rd!=0.
  - WB to a non-pending register: ignored, count unchanged.
  - Set and clear of the same index in one cycle (only possible with WB_BYPASS=1): set wins, count unchanged.
- count: +1 on set, -1 on clear, net 0 on both. It never exceeds MAX_OUTSTANDING and never goes below 0.
- o_outstanding = count.
- FSM (registered, 1-cycle transitions):
  - RUN -> DRAIN: i_id_valid & i_serialize & count!=0 & ~i_flush.
  - DRAIN -> RUN: count==0 at the edge (or count==1 with a clear in the same cycle). The serializing instruction issues in the first RUN cycle if i_ex_ready.
  - Any state -> FLUSH: i_flush high (has priority over all other transitions).
  - FLUSH -> RUN: unconditionally after 1 cycle. No issue in FLUSH. Scoreboard keeps entries of already-issued instructions, which still write back.
- o_stall_cycles increments when state!=FLUSH & i_id_valid & ~o_issue & ~i_flush. It saturates at 0xFFFFFFFF.
- Latency: a hazard-free instruction issues in the same cycle it is presented. A dependent instruction issues in the cycle after the producer's WB write (WB_BYPASS=0), or in the same cycle as that write (WB_BYPASS=1).

Decomposition:
- The shared parameters header gets:
  - FSM state encodings (HZ_RUN=2'd0, HZ_DRAIN=2'd1, HZ_FLUSH=2'd2);
  - REG_ADDR_W=5;
  - opcode-class decode constants (used upstream to derive i_rs*_used, i_rd_we and i_serialize).
- One natural sub-module: hz_scoreboard. It holds the 32-bit pend vector plus count, provides set/clear ports and two read ports, and has a registered count.

Test Plan:
1. Reset: hold rst 2 cycles with i_id_valid=1 -> o_issue=0, o_id_ready=0. After release: o_outstanding=0, o_stall_cycles=0.
2. RAW:
   - Issue rd=5 (we=1), then rs1=5 used -> stall; o_stall_cycles counts up.
   - WB rd=5 -> with WB_BYPASS=0 the consumer issues on the next cycle; with WB_BYPASS=1 it issues in the same cycle.
3. Full:
   - MAX_OUTSTANDING=4: issue writes to x1..x4 -> o_outstanding=4. A 5th write (x6) stalls, while a store (rd_we=0) with no hazard issues.
   - WB x2 -> x6 issues the next cycle.
4. Serialize: with x3 pending, present i_serialize=1 -> DRAIN, o_id_ready=0. WB x3 -> RUN next cycle, then the instruction issues.
5. Flush: assert i_flush during DRAIN with x3 pending -> FLUSH for 1 cycle with o_issue=0, then RUN. sb[3] is still set; the WB clears it and o_outstanding drops to 0.
6. x0 and spurious WB: issue rd=0 -> o_outstanding unchanged. WB to non-pending x7 -> no change. Simultaneous set/clear of x9 (WB_BYPASS=1) -> sb[9]=1, count unchanged.
